// File: rtl/nbit_mosi_spi_rx_pkg.sv
// Shared definitions for the SPI MOSI receiver: FSM state and D/C flag encodings,
// also used by the matching MOSI transmitter.
package nbit_mosi_spi_rx_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_t;

    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

endpackage

// File: rtl/nbit_mosi_spi_rx_if.sv
// Bundle of the SPI line inputs and the valid/ready word output of the receiver.
// The master modport is the side driving the link and consuming words.
interface nbit_mosi_spi_rx_if #(
    parameter int WIDTH = 8
);
    logic             i_CS;
    logic             i_MOSI;
    logic             i_DC;
    logic             i_READY;
    logic [WIDTH-1:0] o_DATA;
    logic             o_DC;
    logic             o_VALID;
    logic             o_BUSY;
    logic             o_OVERRUN;
    logic             o_FRAME_ERR;

    modport master (
        output i_CS, i_MOSI, i_DC, i_READY,
        input  o_DATA, o_DC, o_VALID, o_BUSY, o_OVERRUN, o_FRAME_ERR
    );

    modport slave (
        input  i_CS, i_MOSI, i_DC, i_READY,
        output o_DATA, o_DC, o_VALID, o_BUSY, o_OVERRUN, o_FRAME_ERR
    );
endinterface

// File: rtl/nbit_spi_deserializer.sv
// MSB-first deserializer: shift register, bit counter, word-complete and frame-error strobes.
// word/word_done/frame_err are combinational for the current edge; the caller registers them.
module nbit_spi_deserializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             shift_en,
    input  logic             mosi,
    output logic [WIDTH-1:0] word,
    output logic             word_done,
    output logic             frame_err,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // Only WIDTH-1 bits need storing: the final bit is taken straight from mosi.
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-2:0] shift_reg, shift_next;
    logic [WIDTH-1:0] shifted;

    genvar gi;
    assign shifted[0] = mosi;
    generate
        for (gi = 1; gi < WIDTH; gi++) begin : g_shift
            assign shifted[gi] = shift_reg[gi-1];
        end
    endgenerate

    always_comb begin
        count_next = count_reg;
        shift_next = shift_reg;
        word_done  = 1'b0;
        frame_err  = 1'b0;
        if (shift_en) begin
            shift_next = shifted[WIDTH-2:0];
            if (count_reg == LAST) begin
                count_next = '0;
                word_done  = 1'b1;
            end else begin
                count_next = count_reg + CW'(1);
            end
        end else begin
            count_next = '0;
            shift_next = '0;
            frame_err  = (count_reg != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
            shift_reg <= '0;
        end else begin
            count_reg <= count_next;
            shift_reg <= shift_next;
        end
    end

    assign word = shifted;
    assign busy = (count_reg != '0);

endmodule

// File: rtl/nbit_mosi_spi_rx.sv
// SPI MOSI receive end (SCK/CS/MOSI/DC) with a one-word valid/ready output register.
// Optional SPI_RX_WORD_COUNT_EN adds o_WORD_CNT counting words loaded into the output.
module nbit_mosi_spi_rx
    import nbit_mosi_spi_rx_pkg::*;
#(
    parameter int WIDTH = 8
`ifdef SPI_RX_WORD_COUNT_EN
    ,
    parameter int CNT_WIDTH = 16
`endif
) (
    input  logic                 i_SCK,
    input  logic                 i_RST,
    nbit_mosi_spi_rx_if.slave    bus
`ifdef SPI_RX_WORD_COUNT_EN
    ,
    output logic [CNT_WIDTH-1:0] o_WORD_CNT
`endif
);
    rx_state_t        state_reg, state_next;
    logic             shift_en;
    logic [WIDTH-1:0] word;
    logic             word_done;
    logic             frame_err;
    logic             busy;

    logic [WIDTH-1:0] data_reg;
    logic             dc_reg;
    logic             valid_reg;
    logic             overrun_reg;
    logic             frame_err_reg;
    logic             load;

    nbit_spi_deserializer #(
        .WIDTH (WIDTH)
    ) u_deser (
        .clk       (i_SCK),
        .srst      (i_RST),
        .shift_en  (shift_en),
        .mosi      (bus.i_MOSI),
        .word      (word),
        .word_done (word_done),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always_ff @(posedge i_SCK) begin
        if (i_RST) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        shift_en   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!bus.i_CS) begin
                    state_next = SHIFT;
                    shift_en   = 1'b1;
                end
            end
            SHIFT: begin
                if (!bus.i_CS) shift_en   = 1'b1;
                else           state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // A completed word is taken if the holder is empty or is being drained on this same edge.
    assign load = word_done && (!valid_reg || bus.i_READY);

    always_ff @(posedge i_SCK) begin
        if (i_RST) begin
            data_reg      <= '0;
            dc_reg        <= DC_CMD;
            valid_reg     <= 1'b0;
            overrun_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            overrun_reg   <= word_done && !load;
            frame_err_reg <= frame_err;
            if (load) begin
                data_reg  <= word;
                dc_reg    <= bus.i_DC ? DC_DATA : DC_CMD;
                valid_reg <= 1'b1;
            end else if (valid_reg && bus.i_READY) begin
                valid_reg <= 1'b0;
            end
        end
    end

`ifdef SPI_RX_WORD_COUNT_EN
    logic [CNT_WIDTH-1:0] word_cnt_reg;

    always_ff @(posedge i_SCK) begin
        if (i_RST)     word_cnt_reg <= '0;
        else if (load) word_cnt_reg <= word_cnt_reg + CNT_WIDTH'(1);
    end

    assign o_WORD_CNT = word_cnt_reg;
`endif

    assign bus.o_DATA      = data_reg;
    assign bus.o_DC        = dc_reg;
    assign bus.o_VALID     = valid_reg;
    assign bus.o_BUSY      = busy;
    assign bus.o_OVERRUN   = overrun_reg;
    assign bus.o_FRAME_ERR = frame_err_reg;

endmodule

// File: tb/tb_nbit_mosi_spi_rx.sv
// Self-checking bench for nbit_mosi_spi_rx: directed scenarios plus randomized traffic
// against a word-level reference model. Define SPI_RX_WORD_COUNT_EN to cover o_WORD_CNT.
module tb_nbit_mosi_spi_rx;
    import nbit_mosi_spi_rx_pkg::*;

    localparam int W = 8;
`ifdef SPI_RX_WORD_COUNT_EN
    localparam int CW = 16;
    logic [CW-1:0] o_WORD_CNT;
`endif

    logic i_SCK;
    logic i_RST;
    nbit_mosi_spi_rx_if #(.WIDTH(W)) bus ();

    nbit_mosi_spi_rx #(
        .WIDTH (W)
`ifdef SPI_RX_WORD_COUNT_EN
        ,
        .CNT_WIDTH (CW)
`endif
    ) dut (
        .i_SCK (i_SCK),
        .i_RST (i_RST),
        .bus   (bus)
`ifdef SPI_RX_WORD_COUNT_EN
        ,
        .o_WORD_CNT (o_WORD_CNT)
`endif
    );

    initial i_SCK = 1'b0;
    always #5 i_SCK = ~i_SCK;

    int checks = 0;
    int errors = 0;

    // Word-level reference model.
    int         m_bits;
    int         m_acc;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_dc;
    logic       m_ovr;
    logic       m_ferr;
    int         m_cnt;

    // Observations gathered while stepping.
    logic [8:0]  beats[$];
    logic [8:0]  exp_beats[$];
    int          n_ovr;
    int          n_ferr;
    int          n_diff;
    logic [12:0] first_dut;
    logic [12:0] first_exp;

    function automatic logic [12:0] dut_vec();
        return {bus.o_VALID, bus.o_DATA, bus.o_DC, bus.o_OVERRUN, bus.o_FRAME_ERR, bus.o_BUSY};
    endfunction

    function automatic logic [12:0] exp_vec();
        return {m_valid, m_data, m_dc, m_ovr, m_ferr, (m_bits != 0)};
    endfunction

    task automatic model_update(input logic cs, input logic mosi, input logic dc,
                                input logic ready, input logic rst);
        logic consumed;
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
        if (rst) begin
            m_bits = 0; m_acc = 0; m_valid = 1'b0; m_data = '0; m_dc = 1'b0; m_cnt = 0;
            return;
        end
        consumed = m_valid && ready;
        if (consumed) exp_beats.push_back({m_dc, m_data});
        if (!cs) begin
            m_acc  = (m_acc * 2 + int'(mosi)) % 256;
            m_bits = m_bits + 1;
            if (m_bits == W) begin
                m_bits = 0;
                if (!m_valid || ready) begin
                    m_data  = 8'(m_acc);
                    m_dc    = dc;
                    m_valid = 1'b1;
                    m_cnt   = (m_cnt + 1) % 65536;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (consumed) begin
                m_valid = 1'b0;
            end
        end else begin
            if (m_bits != 0) m_ferr = 1'b1;
            m_bits = 0;
            m_acc  = 0;
            if (consumed) m_valid = 1'b0;
        end
    endtask

    // Drive one SCK period from a falling edge and record what the DUT shows afterwards.
    task automatic step(input logic cs, input logic mosi, input logic dc,
                        input logic ready, input logic rst);
        i_RST       = rst;
        bus.i_CS    = cs;
        bus.i_MOSI  = mosi;
        bus.i_DC    = dc;
        bus.i_READY = ready;
        if (!rst && bus.o_VALID && ready) beats.push_back({bus.o_DC, bus.o_DATA});
        @(posedge i_SCK);
        model_update(cs, mosi, dc, ready, rst);
        @(negedge i_SCK);
        if (bus.o_OVERRUN)   n_ovr++;
        if (bus.o_FRAME_ERR) n_ferr++;
        if (dut_vec() !== exp_vec()) begin
            if (n_diff == 0) begin first_dut = dut_vec(); first_exp = exp_vec(); end
            n_diff++;
        end
`ifdef SPI_RX_WORD_COUNT_EN
        if (o_WORD_CNT !== CW'(m_cnt)) n_diff++;
`endif
    endtask

    task automatic clear_obs();
        beats.delete();
        exp_beats.delete();
        n_ovr = 0; n_ferr = 0; n_diff = 0;
        first_dut = '0; first_exp = '0;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        clear_obs();
    endtask

    // D/C is randomized on every bit but the last, where it must be sampled.
    task automatic send_word(input logic [7:0] data, input logic dc, input logic ready);
        for (int i = 7; i >= 0; i--)
            step(1'b0, data[i], (i == 0) ? dc : 1'($urandom), ready, 1'b0);
    endtask

    task automatic idle(input int n, input logic ready);
        for (int i = 0; i < n; i++) step(1'b1, 1'($urandom), 1'($urandom), ready, 1'b0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'($urandom), 1'($urandom), 1'b1, 1'b1);
        checks++;
        if (dut_vec() !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", dut_vec(), 13'd0);
        end
`ifdef SPI_RX_WORD_COUNT_EN
        checks++;
        if (o_WORD_CNT !== '0) begin
            errors++;
            $display("FAIL reset_word_cnt: got %0d expected 0", o_WORD_CNT);
        end
`endif
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        clear_obs();
    endtask

    task automatic test_loopback();
        logic [8:0] want[4];
        want[0] = {DC_CMD, 8'hAA};
        want[1] = {DC_DATA, 8'hFF};
        want[2] = {DC_DATA, 8'h00};
        want[3] = {DC_CMD, 8'hC2};
        do_reset();
        for (int k = 0; k < 4; k++) send_word(want[k][7:0], want[k][8], 1'b1);
        idle(3, 1'b1);
        checks++;
        if (beats.size() != 4) begin
            errors++;
            $display("FAIL loopback_beat_count: got %0d expected 4", beats.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (beats[k] !== want[k]) begin
                    errors++;
                    $display("FAIL loopback_beat%0d: got %h expected %h", k, beats[k], want[k]);
                end
            end
        end
`ifdef SPI_RX_WORD_COUNT_EN
        checks++;
        if (o_WORD_CNT !== CW'(4)) begin
            errors++;
            $display("FAIL loopback_word_cnt: got %0d expected 4", o_WORD_CNT);
        end
`endif
        checks++;
        if (n_diff != 0) begin
            errors++;
            $display("FAIL loopback_model: got %h expected %h (%0d cycles differ)", first_dut, first_exp, n_diff);
        end
    endtask

    task automatic test_single_hold();
        do_reset();
        send_word(8'hF1, DC_DATA, 1'b0);
        idle(5, 1'b0);
        checks++;
        if ({bus.o_VALID, bus.o_DC, bus.o_DATA} !== {1'b1, 1'b1, 8'hF1}) begin
            errors++;
            $display("FAIL single_hold: got v=%b dc=%b data=%h expected v=1 dc=1 data=f1",
                     bus.o_VALID, bus.o_DC, bus.o_DATA);
        end
        idle(1, 1'b1);
        checks++;
        if (bus.o_VALID !== 1'b0) begin
            errors++;
            $display("FAIL single_release: got valid=%b expected 0", bus.o_VALID);
        end
        checks++;
        if (beats.size() != 1 || beats[0] !== 9'h1F1) begin
            errors++;
            $display("FAIL single_beat: got %0d beats expected 1 beat of 1f1", beats.size());
        end
        checks++;
        if (n_diff != 0) begin
            errors++;
            $display("FAIL single_model: got %h expected %h (%0d cycles differ)", first_dut, first_exp, n_diff);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        send_word(8'hCD, DC_CMD, 1'b0);
        send_word(8'h82, DC_DATA, 1'b0);
        idle(2, 1'b0);
        checks++;
        if ({bus.o_VALID, bus.o_DC, bus.o_DATA} !== {1'b1, 1'b0, 8'hCD}) begin
            errors++;
            $display("FAIL overrun_keep: got v=%b dc=%b data=%h expected v=1 dc=0 data=cd",
                     bus.o_VALID, bus.o_DC, bus.o_DATA);
        end
        checks++;
        if (n_ovr != 1) begin
            errors++;
            $display("FAIL overrun_pulses: got %0d expected 1", n_ovr);
        end
`ifdef SPI_RX_WORD_COUNT_EN
        checks++;
        if (o_WORD_CNT !== CW'(1)) begin
            errors++;
            $display("FAIL overrun_word_cnt: got %0d expected 1", o_WORD_CNT);
        end
`endif
        checks++;
        if (n_diff != 0) begin
            errors++;
            $display("FAIL overrun_model: got %h expected %h (%0d cycles differ)", first_dut, first_exp, n_diff);
        end
        idle(1, 1'b1);
    endtask

    task automatic test_frame_err();
        logic [7:0] part;
        part = 8'h5A;
        do_reset();
        for (int i = 7; i >= 3; i--) step(1'b0, part[i], 1'b1, 1'b1, 1'b0);
        idle(3, 1'b1);
        checks++;
        if (n_ferr != 1 || beats.size() != 0) begin
            errors++;
            $display("FAIL frame_err_pulse: got %0d pulses %0d beats expected 1 pulse 0 beats",
                     n_ferr, beats.size());
        end
        send_word(8'h3C, DC_DATA, 1'b1);
        idle(2, 1'b1);
        checks++;
        if (beats.size() != 1 || beats[0] !== 9'h13C) begin
            errors++;
            $display("FAIL frame_err_recover: got %0d beats expected 1 beat of 13c", beats.size());
        end
        checks++;
        if (n_diff != 0) begin
            errors++;
            $display("FAIL frame_err_model: got %h expected %h (%0d cycles differ)", first_dut, first_exp, n_diff);
        end
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] part;
        part = 8'hA5;
        do_reset();
        send_word(8'h77, DC_DATA, 1'b0);
        for (int i = 7; i >= 4; i--) step(1'b0, part[i], 1'b0, 1'b0, 1'b0);
        step(1'b0, part[3], 1'b0, 1'b0, 1'b1);
        checks++;
        if (dut_vec() !== 13'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %h expected %h", dut_vec(), 13'd0);
        end
        clear_obs();
        send_word(8'h81, DC_CMD, 1'b1);
        idle(2, 1'b1);
        checks++;
        if (beats.size() != 1 || beats[0] !== 9'h081) begin
            errors++;
            $display("FAIL reset_mid_recover: got %0d beats expected 1 beat of 081", beats.size());
        end
        checks++;
        if (n_diff != 0) begin
            errors++;
            $display("FAIL reset_mid_model: got %h expected %h (%0d cycles differ)", first_dut, first_exp, n_diff);
        end
    endtask

    task automatic test_random();
        logic [7:0] data;
        logic       dc;
        int         nb;
        do_reset();
        for (int w = 0; w < 60; w++) begin
            data = 8'($urandom);
            dc   = 1'($urandom);
            nb   = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 8;
            for (int i = 0; i < nb; i++)
                step(1'b0, data[7-i], (i == 7) ? dc : 1'($urandom), 1'($urandom), 1'b0);
            idle((nb < 8) ? $urandom_range(1, 2) : $urandom_range(0, 2), 1'($urandom));
        end
        idle(4, 1'b1);
        checks++;
        if (n_diff != 0) begin
            errors++;
            $display("FAIL random_model: got %h expected %h (%0d cycles differ)", first_dut, first_exp, n_diff);
        end
        checks++;
        if (beats.size() != exp_beats.size()) begin
            errors++;
            $display("FAIL random_beat_count: got %0d expected %0d", beats.size(), exp_beats.size());
        end else begin
            for (int k = 0; k < beats.size(); k++) begin
                checks++;
                if (beats[k] !== exp_beats[k]) begin
                    errors++;
                    $display("FAIL random_beat%0d: got %h expected %h", k, beats[k], exp_beats[k]);
                end
            end
        end
    endtask

    initial begin
        i_RST       = 1'b1;
        bus.i_CS    = 1'b1;
        bus.i_MOSI  = 1'b0;
        bus.i_DC    = 1'b0;
        bus.i_READY = 1'b0;
        m_bits = 0; m_acc = 0; m_valid = 1'b0; m_data = '0; m_dc = 1'b0;
        m_ovr = 1'b0; m_ferr = 1'b0; m_cnt = 0;
        clear_obs();
        @(negedge i_SCK);
        test_reset();
        test_loopback();
        test_single_hold();
        test_overrun();
        test_frame_err();
        test_reset_mid_word();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
